// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, port count and arbiter FSM states
package dmem_arbiter_pkg;
  localparam int RISCV_ADDR_WIDTH = 32;
  localparam int RISCV_WORD_WIDTH = 32;
  localparam int DMEM_PORTS = 2;
  typedef enum logic {ARB_IDLE, ARB_BUSY} dmem_arb_state_e;
endpackage

// File: rtl/dmem_arbiter_rr.sv
// rr_arbiter_2: two-way round-robin pick, one-hot grant
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);
  always_comb grant = &req ? (last_grant ? 2'b01 : 2'b10) : req;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between LSU and debug/DMA with a watchdog
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DMEM_PORTS-1:0]                             req_valid_i,
  input  logic [DMEM_PORTS-1:0][RISCV_ADDR_WIDTH-1:0]       req_addr_i,
  input  logic [DMEM_PORTS-1:0][RISCV_WORD_WIDTH-1:0]       req_wdata_i,
  input  logic [DMEM_PORTS-1:0][RISCV_WORD_WIDTH/8-1:0]     req_we_i,
  output logic [DMEM_PORTS-1:0]                             req_done_o,
  output logic [DMEM_PORTS-1:0]                             req_err_o,
  output logic [RISCV_WORD_WIDTH-1:0]                       req_rdata_o,
  output logic                                              dmem_valid_o,
  input  logic                                              dmem_ready_i,
  output logic [RISCV_ADDR_WIDTH-1:0]                       dmem_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0]                       dmem_wdata_o,
  output logic [RISCV_WORD_WIDTH/8-1:0]                     dmem_we_o,
  input  logic [RISCV_WORD_WIDTH-1:0]                       dmem_rdata_i
);
  dmem_arb_state_e               state;
  logic                          owner, last_grant, busy, fin, tmo;
  logic [1:0]                    grant;
  logic [CNT_W-1:0]              cnt;
  logic [RISCV_ADDR_WIDTH-1:0]   addr_q;
  logic [RISCV_WORD_WIDTH-1:0]   wdata_q;
  logic [RISCV_WORD_WIDTH/8-1:0] we_q;
  rr_arbiter_2 u_rr (.req(req_valid_i), .last_grant(last_grant), .grant(grant));
  // ready on the final watchdog cycle completes normally rather than aborting
  always_comb begin
    busy = state == ARB_BUSY;
    fin = busy & dmem_ready_i;
    tmo = busy & ~dmem_ready_i & (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    req_done_o = fin ? (owner ? 2'b10 : 2'b01) : 2'b00;
    req_err_o = tmo ? (owner ? 2'b10 : 2'b01) : 2'b00;
    req_rdata_o = fin ? dmem_rdata_i : '0;
    dmem_valid_o = busy;
    dmem_we_o = busy ? we_q : '0;
  end
  assign dmem_addr_o = addr_q;
  assign dmem_wdata_o = wdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_IDLE;
      owner <= 1'b0;
      last_grant <= 1'b1;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= '0;
    end else if (!busy) begin
      if (|req_valid_i) begin
        state <= ARB_BUSY;
        owner <= grant[1];
        last_grant <= grant[1];
        cnt <= '0;
        addr_q <= req_addr_i[grant[1]];
        wdata_q <= req_wdata_i[grant[1]];
        we_q <= req_we_i[grant[1]];
      end
    end else if (fin || tmo) begin
      state <= ARB_IDLE;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a 4-cycle watchdog
module tb_dmem_arbiter;
  logic             clk = 0, rst = 1;
  logic [1:0]       req_valid = '0;
  logic [1:0][31:0] req_addr = '0, req_wdata = '0;
  logic [1:0][3:0]  req_we = '0;
  logic [1:0]       done, err;
  logic [31:0]      rdata, dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]       dmem_we;
  logic             dmem_valid, dmem_ready = 0;
  int tests = 0, fails = 0;
  typedef struct {
    int port;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] we;
    bit is_err;
  } exp_t;
  exp_t q[$];
  exp_t e;
  logic [1:0] oh, exp_done, exp_err;
  logic [31:0] exp_rd;

  dmem_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata), .req_we_i(req_we), .req_done_o(done), .req_err_o(err),
    .req_rdata_o(rdata), .dmem_valid_o(dmem_valid), .dmem_ready_i(dmem_ready),
    .dmem_addr_o(dmem_addr), .dmem_wdata_o(dmem_wdata), .dmem_we_o(dmem_we),
    .dmem_rdata_i(dmem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dmem_valid && q.size() > 0) begin
      tests++;
      if (dmem_addr !== q[0].addr || dmem_wdata !== q[0].wdata || dmem_we !== q[0].we) begin
        fails++;
        $display("FAIL latch: addr=%h wdata=%h we=%b, want addr=%h wdata=%h we=%b",
                 dmem_addr, dmem_wdata, dmem_we, q[0].addr, q[0].wdata, q[0].we);
      end
    end
    if (done !== 2'b00 || err !== 2'b00) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_completion: done=%b err=%b, want none", done, err);
      end else begin
        e = q.pop_front();
        oh = e.port ? 2'b10 : 2'b01;
        exp_done = e.is_err ? 2'b00 : oh;
        exp_err = e.is_err ? oh : 2'b00;
        exp_rd = e.is_err ? 32'h0 : e.rdata;
        if (done !== exp_done || err !== exp_err || rdata !== exp_rd) begin
          fails++;
          $display("FAIL completion: done=%b err=%b rdata=%h, want done=%b err=%b rdata=%h",
                   done, err, rdata, exp_done, exp_err, exp_rd);
        end
      end
    end
  end

  function automatic void expect_txn(input int p, input logic [31:0] a, input logic [31:0] wd,
                                     input logic [3:0] we, input logic [31:0] rd, input bit is_err);
    exp_t t;
    t.port = p; t.addr = a; t.wdata = wd; t.we = we; t.rdata = rd; t.is_err = is_err;
    q.push_back(t);
  endfunction

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    req_addr[p] = a; req_wdata[p] = wd; req_we[p] = we; req_valid[p] = 1'b1;
  endtask

  task automatic wait_busy();
    int n = 0;
    while (!dmem_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!dmem_valid) begin
      tests++; fails++;
      $display("FAIL wait_busy: dmem_valid=0 after %0d cycles, want 1", n);
    end
  endtask

  // raises ready in the lat-th BUSY cycle, returns #1 into the following IDLE cycle
  task automatic serve(input int lat, input logic [31:0] rd);
    wait_busy();
    repeat (lat - 1) begin @(posedge clk); #1; end
    dmem_ready = 1; dmem_rdata = rd;
    @(posedge clk); #1;
    dmem_ready = 0; dmem_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    #2;
    tests++;
    if (dmem_valid !== 0 || dmem_we !== 0 || dmem_addr !== 0 || dmem_wdata !== 0) begin
      fails++;
      $display("FAIL reset_dmem: valid=%b we=%b addr=%h wdata=%h, want all 0", dmem_valid, dmem_we, dmem_addr, dmem_wdata);
    end
    tests++;
    if (done !== 0 || err !== 0 || rdata !== 0) begin
      fails++;
      $display("FAIL reset_req: done=%b err=%b rdata=%h, want all 0", done, err, rdata);
    end
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic test_round_robin();
    set_req(0, 32'h200, 32'h0, 4'b0000);
    set_req(1, 32'h300, 32'h0, 4'b0000);
    for (int i = 0; i < 4; i++) expect_txn(i % 2, i % 2 ? 32'h300 : 32'h200, 32'h0, 4'b0000, 32'h1000 + i, 0);
    for (int i = 0; i < 4; i++) serve(2, 32'h1000 + i);
    req_valid = '0;
  endtask

  task automatic test_read();
    set_req(0, 32'h100, 32'h0, 4'b0000);
    expect_txn(0, 32'h100, 32'h0, 4'b0000, 32'hDEADBEEF, 0);
    serve(3, 32'hDEADBEEF);
    req_valid[0] = 0;
  endtask

  task automatic test_write();
    @(posedge clk); #1;
    set_req(1, 32'h400, 32'hABCD0000, 4'b1100);
    expect_txn(1, 32'h400, 32'hABCD0000, 4'b1100, 32'h0, 0);
    @(posedge clk); #1;
    tests++;
    if (dmem_valid !== 1 || dmem_we !== 4'b1100) begin
      fails++;
      $display("FAIL write_issue: valid=%b we=%b, want valid=1 we=1100", dmem_valid, dmem_we);
    end
    dmem_ready = 1;
    #1;
    tests++;
    if (done !== 2'b10) begin
      fails++;
      $display("FAIL write_latency: done=%b, want 10", done);
    end
    @(posedge clk); #1;
    dmem_ready = 0; req_valid[1] = 0;
  endtask

  task automatic test_timeout();
    set_req(0, 32'h500, 32'h0, 4'b0000);
    expect_txn(0, 32'h500, 32'h0, 4'b0000, 32'h0, 1);
    wait_busy();
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      tests++;
      if (err !== (k == 4 ? 2'b01 : 2'b00) || done !== 2'b00) begin
        fails++;
        $display("FAIL timeout_cycle%0d: err=%b done=%b, want err=%b done=00", k, err, done, k == 4 ? 2'b01 : 2'b00);
      end
    end
    @(posedge clk); #1;
    tests++;
    if (dmem_valid !== 0) begin
      fails++;
      $display("FAIL timeout_idle: dmem_valid=%b, want 0", dmem_valid);
    end
    set_req(0, 32'h504, 32'h0, 4'b0000);
    expect_txn(0, 32'h504, 32'h0, 4'b0000, 32'h0BADF00D, 0);
    serve(4, 32'h0BADF00D);
    req_valid[0] = 0;
  endtask

  task automatic test_ignore();
    set_req(1, 32'h800, 32'h11112222, 4'b0011);
    expect_txn(1, 32'h800, 32'h11112222, 4'b0011, 32'hCAFE0001, 0);
    expect_txn(0, 32'h900, 32'h33334444, 4'b1111, 32'hCAFE0002, 0);
    wait_busy();
    set_req(0, 32'h900, 32'h33334444, 4'b1111);
    req_addr[1] = 32'hFFF0; req_wdata[1] = 32'h55555555; req_we[1] = 4'b1000;
    serve(3, 32'hCAFE0001);
    req_valid[1] = 0;
    serve(2, 32'hCAFE0002);
    req_valid[0] = 0;
  endtask

  task automatic test_reset_busy();
    set_req(1, 32'hA00, 32'h0, 4'b0000);
    wait_busy();
    @(posedge clk); #1;
    rst = 1;
    #1;
    tests++;
    if (dmem_valid !== 0 || done !== 0 || err !== 0) begin
      fails++;
      $display("FAIL reset_busy: valid=%b done=%b err=%b, want all 0", dmem_valid, done, err);
    end
    set_req(0, 32'hB00, 32'h0, 4'b0000);
    expect_txn(0, 32'hB00, 32'h0, 4'b0000, 32'h77770000, 0);
    expect_txn(1, 32'hA00, 32'h0, 4'b0000, 32'h77770001, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    serve(2, 32'h77770000);
    req_valid[0] = 0;
    serve(2, 32'h77770001);
    req_valid[1] = 0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_write();
    test_timeout();
    test_ignore();
    test_reset_busy();
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
